// File: rtl/addr_sequencer_pkg.sv
// Shared definitions for the message-ROM address sequencer.
//   seq_state_t : 2-bit playback state encoding
//   DWELL_W     : width of the per-entry dwell counter
//   is_live()   : true in states where addr carries playback data
package addr_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

   localparam int DWELL_W = 8;

   function automatic logic is_live(input seq_state_t s);
      return (s == S_RUN) || (s == S_PAUSE);
   endfunction

endpackage

// File: rtl/addr_sequencer_if.sv
// Control/status bundle between the button/switch logic and the sequencer.
//   start, stop, hold, loop : playback controls (levels)
//   addr                    : ROM/display address
//   addr_valid, busy, done  : playback status
// master = controlling logic, slave = addr_sequencer.
interface addr_sequencer_if #(
   parameter int ADDR_W = 4
) ();

   logic              start;
   logic              stop;
   logic              hold;
   logic              loop;
   logic [ADDR_W-1:0] addr;
   logic              addr_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, stop, hold, loop,
      input  addr, addr_valid, busy, done
   );

   modport slave (
      input  start, stop, hold, loop,
      output addr, addr_valid, busy, done
   );

endinterface

// File: rtl/addr_sequencer_tick_gen.sv
// Prescaler producing the playback tick.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable; count freezes while low
//   clr        : zero the count (wins over en)
//   tick       : high when count has reached PRESCALE-1 and en is high
module addr_sequencer_tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W    = $clog2(PRESCALE) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = en && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/addr_sequencer.sv
// Message-ROM playback controller: on start, steps addr through
// 0..NUM_ENTRIES-1, holding each entry DWELL ticks; supports hold, stop,
// one-shot or loop playback.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : control inputs and registered status/address outputs
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; counters cleared
// S_RUN   | playing; dwell counter advances on each tick
// S_PAUSE | hold asserted; prescaler and dwell counter frozen
// S_DONE  | one-cycle completion of a one-shot playback, done pulses
module addr_sequencer
   import addr_sequencer_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int NUM_ENTRIES = 15,
   parameter int DWELL       = 11,
   parameter int PRESCALE    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   addr_sequencer_if.slave bus
);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(NUM_ENTRIES - 1);

   seq_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               valid_q, busy_q, done_q;
   logic               active, tick, tick_en, tick_clr;

   // Counting is enabled in PAUSE too once hold drops, so each cycle of hold
   // costs exactly one cycle of dwell time. stop suppresses a coinciding tick.
   assign active   = is_live(state_q);
   assign tick_en  = active && !bus.hold && !bus.stop;
   assign tick_clr = !active;

   addr_sequencer_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tick_en),
      .clr   (tick_clr),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      dwell_d = dwell_q;
      case (state_q)
         S_IDLE: begin
            dwell_d = '0;
            if (bus.start && !bus.stop) begin
               state_d = S_RUN;
               addr_d  = '0;
            end
         end
         S_RUN, S_PAUSE: begin
            if (bus.stop) begin
               state_d = S_IDLE;
               addr_d  = '0;
               dwell_d = '0;
            end else if (bus.hold) begin
               state_d = S_PAUSE;
            end else begin
               state_d = S_RUN;
               if (tick) begin
                  if (dwell_q == DWELL_LAST) begin
                     dwell_d = '0;
                     if (addr_q != ADDR_LAST) begin
                        addr_d = addr_q + ADDR_W'(1);
                     end else if (bus.loop) begin
                        addr_d = '0;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     dwell_d = dwell_q + DWELL_W'(1);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         dwell_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dwell_q <= dwell_d;
         valid_q <= is_live(state_d);
         busy_q  <= is_live(state_d);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign bus.addr       = addr_q;
   assign bus.addr_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
module tb_addr_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   addr_sequencer_if #(.ADDR_W(4)) bus_a ();
   addr_sequencer_if #(.ADDR_W(4)) bus_b ();

   addr_sequencer #(
      .ADDR_W(4), .NUM_ENTRIES(4), .DWELL(3), .PRESCALE(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a)
   );

   addr_sequencer #(
      .ADDR_W(4), .NUM_ENTRIES(1), .DWELL(1), .PRESCALE(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rst_n, start, stop, hold, loop;
      int         cycles;
      logic [3:0] addr;
      logic       valid, busy, done, chk_addr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic s, input logic p, input logic h,
                      input logic l, input int n, input logic [3:0] a,
                      input logic v, input logic b, input logic d,
                      input logic ca = 1'b1);
      vec_t x;
      x.rst_n = r; x.start = s; x.stop = p; x.hold = h; x.loop = l;
      x.cycles = n; x.addr = a; x.valid = v; x.busy = b; x.done = d;
      x.chk_addr = ca;
      tbl.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // {addr, addr_valid, busy, done}; addr masked to 0 when not checked
   task automatic chk_a(input string nm, input logic [3:0] a, input logic v,
                        input logic b, input logic d, input logic ca);
      logic [6:0] act, exp;
      act = {ca ? bus_a.addr : 4'h0, bus_a.addr_valid, bus_a.busy, bus_a.done};
      exp = {ca ? a : 4'h0, v, b, d};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: {addr,valid,busy,done} got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input logic v, input logic b, input logic d);
      logic [6:0] act, exp;
      act = {bus_b.addr, bus_b.addr_valid, bus_b.busy, bus_b.done};
      exp = {4'h0, v, b, d};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: {addr,valid,busy,done} got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic wait_addr_a(input logic [3:0] a, input int budget, input string nm);
      int k = 0;
      while (bus_a.addr !== a && k < budget) begin
         step();
         k++;
      end
      chk(nm, {28'h0, bus_a.addr}, {28'h0, a});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int k;
      logic hold_ok;

      rst_n = 1'b0;
      bus_a.start = 0; bus_a.stop = 0; bus_a.hold = 0; bus_a.loop = 0;
      bus_b.start = 0; bus_b.stop = 0; bus_b.hold = 0; bus_b.loop = 0;

      //  r  s  p  h  l  n   a  v  b  d
      add(0, 0, 0, 0, 0, 2,  0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 2,  0, 0, 0, 0);
      // one-shot; start kept high while running must not restart
      add(1, 1, 0, 0, 0, 1,  0, 1, 1, 0);
      add(1, 1, 0, 0, 0, 5,  0, 1, 1, 0);
      add(1, 1, 0, 0, 0, 6,  1, 1, 1, 0);
      add(1, 1, 0, 0, 0, 6,  2, 1, 1, 0);
      add(1, 0, 0, 0, 0, 6,  3, 1, 1, 0);
      add(1, 0, 0, 0, 0, 1,  3, 0, 0, 1);
      add(1, 0, 0, 0, 0, 2,  0, 0, 0, 0, 1'b0);
      // loop, then drop loop during addr 2 of the second pass
      add(1, 1, 0, 0, 1, 1,  0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 5,  0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 6,  1, 1, 1, 0);
      add(1, 0, 0, 0, 1, 6,  2, 1, 1, 0);
      add(1, 0, 0, 0, 1, 6,  3, 1, 1, 0);
      add(1, 0, 0, 0, 1, 6,  0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 6,  1, 1, 1, 0);
      add(1, 0, 0, 0, 1, 3,  2, 1, 1, 0);
      add(1, 0, 0, 0, 0, 3,  2, 1, 1, 0);
      add(1, 0, 0, 0, 0, 6,  3, 1, 1, 0);
      add(1, 0, 0, 0, 0, 1,  3, 0, 0, 1);
      add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1'b0);
      // stop during addr 2, then start+stop together in IDLE
      add(1, 1, 0, 0, 0, 1,  0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 5,  0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 6,  1, 1, 1, 0);
      add(1, 0, 0, 0, 0, 2,  2, 1, 1, 0);
      add(1, 0, 1, 0, 0, 1,  0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 8,  0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 3,  0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1,  0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n       = tbl[i].rst_n;
         bus_a.start = tbl[i].start;
         bus_a.stop  = tbl[i].stop;
         bus_a.hold  = tbl[i].hold;
         bus_a.loop  = tbl[i].loop;
         for (int c = 0; c < tbl[i].cycles; c++) begin
            step();
            chk_a($sformatf("vec%0d.%0d", i, c), tbl[i].addr, tbl[i].valid,
                  tbl[i].busy, tbl[i].done, tbl[i].chk_addr);
         end
      end
      bus_a.start = 0; bus_a.stop = 0; bus_a.hold = 0; bus_a.loop = 0;

      // hold for 10 cycles mid addr 1: addr 1 visible 6+10 cycles
      bus_a.start = 1;
      step();
      chk_a("hold_start", 0, 1, 1, 0, 1);
      bus_a.start = 0;
      wait_addr_a(4'd1, 20, "hold_reach_addr1");
      cnt = 1;
      step();
      if (bus_a.addr == 4'd1) cnt++;
      bus_a.hold = 1;
      hold_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus_a.addr == 4'd1) cnt++;
         if (!(bus_a.addr_valid && bus_a.busy && !bus_a.done)) hold_ok = 1'b0;
      end
      bus_a.hold = 0;
      k = 0;
      while (bus_a.addr == 4'd1 && k < 30) begin
         step();
         k++;
         if (bus_a.addr == 4'd1) cnt++;
      end
      chk("hold_addr1_cycles", cnt, 16);
      chk("hold_valid_busy", {31'h0, hold_ok}, 32'd1);
      chk_a("hold_next_addr", 2, 1, 1, 0, 1);

      // stop while paused
      bus_a.hold = 1;
      step();
      step();
      chk_a("pause_frozen", 2, 1, 1, 0, 1);
      bus_a.stop = 1;
      step();
      chk_a("pause_stop", 0, 0, 0, 0, 1);
      bus_a.stop = 0;
      bus_a.hold = 0;
      step();
      chk_a("pause_stop_idle", 0, 0, 0, 0, 1);

      // reset mid-run during addr 1
      bus_a.start = 1;
      step();
      bus_a.start = 0;
      wait_addr_a(4'd1, 20, "rst_reach_addr1");
      rst_n = 0;
      step();
      chk_a("rst_midrun", 0, 0, 0, 0, 1);
      rst_n = 1;
      step();
      chk_a("rst_after", 0, 0, 0, 0, 1);
      bus_a.start = 1;
      step();
      chk_a("rst_restart", 0, 1, 1, 0, 1);
      bus_a.start = 0;
      bus_a.stop = 1;
      step();
      chk_a("rst_restart_stop", 0, 0, 0, 0, 1);
      bus_a.stop = 0;

      // minimal configuration, start held high: RUN, DONE, IDLE, repeat
      bus_b.start = 1;
      for (int c = 0; c < 9; c++) begin
         step();
         case (c % 3)
            0:       chk_b($sformatf("edge_run%0d", c), 1, 1, 0);
            1:       chk_b($sformatf("edge_done%0d", c), 0, 0, 1);
            default: chk_b($sformatf("edge_idle%0d", c), 0, 0, 0);
         endcase
      end
      bus_b.start = 0;
      step();
      chk_b("edge_idle_after", 0, 0, 0);

      // single entry with loop: stays on addr 0, no done
      bus_b.start = 1;
      bus_b.loop  = 1;
      step();
      chk_b("edge_loop_start", 1, 1, 0);
      bus_b.start = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk_b($sformatf("edge_loop%0d", c), 1, 1, 0);
      end
      bus_b.stop = 1;
      step();
      chk_b("edge_loop_stop", 0, 0, 0);
      bus_b.stop = 0;
      bus_b.loop = 0;

      // stop coinciding with the final tick: no done
      bus_b.start = 1;
      step();
      chk_b("edge_tickstop_run", 1, 1, 0);
      bus_b.start = 0;
      bus_b.stop  = 1;
      step();
      chk_b("edge_tickstop", 0, 0, 0);
      bus_b.stop = 0;
      step();
      chk_b("edge_tickstop_idle", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
